// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states,
// opcodes, ALU control codes and immediate-format selects.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_ILLEGAL  = 4'd15
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Internal ALU operation class handed from the FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format from the opcode; loads, I-type ALU and unknowns use I
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:  imm_src_of = IMM_S;
      OP_BRANCH: imm_src_of = IMM_B;
      OP_JAL:    imm_src_of = IMM_J;
      default:   imm_src_of = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller (master) and the
// datapath (slave): instruction fields and zero flag in, selects/enables out.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;

  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [1:0] imm_src;
  logic       illegal_instr;
  logic [3:0] state_dbg;

  modport master (
    input  op, funct3, funct7b5, zero,
    output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, alu_control, imm_src, illegal_instr, state_dbg
  );

  modport slave (
    output op, funct3, funct7b5, zero,
    input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, alu_control, imm_src, illegal_instr, state_dbg
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps the FSM's ALU operation class plus funct fields to the
// ALU control code. Purely combinational.
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_control_o
);

  // Subtract only for R-type funct3=000 with funct7[5] set; addi never subtracts
  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: Moore FSM sequencing fetch/decode/execute/
// writeback over a shared memory and ALU, plus imm_src and ALU decode.
module multicycle_controller
  import rv_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_TO_FETCH = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  multicycle_controller_if.master       bus
);

  state_e     state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;

  // State register; reset wins over any in-flight transition
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state and per-state datapath controls; only pc_write sees zero
  always_comb begin
    state_d       = S_FETCH;
    pc_write      = 1'b0;
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    illegal_instr = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write   = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        // ALU precomputes the branch/jump target from oldPC + imm
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_JAL:            state_d = S_JAL;
          OP_BRANCH:         state_d = S_BEQ;
          default: begin
            illegal_instr = 1'b1;
            state_d       = ILLEGAL_TO_FETCH ? S_FETCH : S_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        // PC+4 computed here becomes the link value written in ALUWB
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        // funct3[0] flips the sense: beq takes on zero, bne on not-zero
        alu_src_a = 2'b10;
        alu_op    = ALUOP_SUB;
        pc_write  = bus.zero ^ bus.funct3[0];
        state_d   = S_FETCH;
      end
      S_ILLEGAL: begin
        state_d = S_ILLEGAL;
      end
      default: state_d = S_FETCH;
    endcase
  end

  alu_decoder u_alu_dec (
    .alu_op_i      (alu_op),
    .funct3_i      (bus.funct3),
    .op5_i         (bus.op[5]),
    .funct7b5_i    (bus.funct7b5),
    .alu_control_o (alu_control)
  );

  // Immediate format follows the opcode, silenced once parked in ILLEGAL
  always_comb begin
    imm_src = imm_src_of(bus.op);
    if (state_q == S_ILLEGAL) imm_src = IMM_I;
  end

  assign bus.pc_write      = pc_write;
  assign bus.adr_src       = adr_src;
  assign bus.mem_write     = mem_write;
  assign bus.ir_write      = ir_write;
  assign bus.reg_write     = reg_write;
  assign bus.result_src    = result_src;
  assign bus.alu_src_a     = alu_src_a;
  assign bus.alu_src_b     = alu_src_b;
  assign bus.alu_control   = alu_control;
  assign bus.imm_src       = imm_src;
  assign bus.illegal_instr = illegal_instr;
  assign bus.state_dbg     = state_q;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Control unit for the multicycle RV32I core. It sequences one shared memory and ALU through fetch, decode, execute and writeback states, and decodes opcode/funct fields into datapath selects. It sits beside the multicycle datapath, consumes instruction fields and the ALU zero flag, and drives all enables and muxes. It supports lw, sw, R-type (add/sub/and/or/slt), I-type ALU, beq/bne and jal.

Parameters:
ILLEGAL_TO_FETCH, 1, 1: an unrecognised opcode returns to FETCH. 0: the FSM parks in ILLEGAL until reset.

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high; sampled on rising clk edge
op  in  7  instr[6:0], taken from the instruction register
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
zero  in  1  ALU zero flag
pc_write  out  1  PC register enable
adr_src  out  1  memory address select: 0=PC, 1=ALU result register
mem_write  out  1  data write strobe
ir_write  out  1  instruction/oldPC register enable
reg_write  out  1  register file write enable
result_src  out  2  00=ALUOut, 01=memory data, 10=ALU result
alu_src_a  out  2  00=PC, 01=oldPC, 10=rs1
alu_src_b  out  2  00=rs2, 01=immediate, 10=constant 4
alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
imm_src  out  2  00 I, 01 S, 10 B, 11 J; combinational from op
illegal_instr  out  1  one-cycle pulse in DECODE when op is unrecognised
state_dbg  out  4  current state encoding

Behaviour:
- Moore FSM with a registered state. All outputs except imm_src, alu_control and pc_write are pure functions of state. Any output not listed for a state is 0.
- Reset: state <= FETCH on the next edge. reset has priority over every transition, including reset asserted mid-instruction. During reset cycles the outputs reflect the current state. After release, the first cycle is FETCH.
- States, their outputs, and next state:
  - FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, pc_write=1. Next: DECODE.
  - DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target).
    - op 0000011 or 0100011 -> MEMADR
    - op 0110011 -> EXECUTER
    - op 0010011 -> EXECUTEI
    - op 1101111 -> JAL
    - op 1100011 -> BEQ
    - any other op -> illegal_instr=1, then FETCH (or ILLEGAL per ILLEGAL_TO_FETCH)
  - MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next: op[5]=0 -> MEMREAD, op[5]=1 -> MEMWRITE.
  - MEMREAD: adr_src=1, result_src=00. Next: MEMWB.
  - MEMWB: result_src=01, reg_write=1. Next: FETCH.
  - MEMWRITE: adr_src=1, result_src=00, mem_write=1. Next: FETCH.
  - EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10. Next: ALUWB.
  - EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10. Next: ALUWB.
  - ALUWB: result_src=00, reg_write=1. Next: FETCH.
  - JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1. Next: ALUWB.
  - BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write = zero XOR funct3[0] (beq when funct3=000, bne when 001). Next: FETCH.
  - ILLEGAL: all outputs 0; self-loop.
- alu_op is internal, 2 bits:
  - 00 -> add
  - 01 -> sub
  - 10 -> decode funct3:
    - 000 -> sub if (op[5] & funct7b5), else add
    - 010 -> slt
    - 110 -> or
    - 111 -> and
    - other -> add
- Instruction latency in cycles: lw 5, sw 4, R/I 4, jal 4, beq/bne 3, illegal 2.
- No combinational path from zero to any output other than pc_write.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - state encodings, 4 bits: FETCH=0 … BEQ=10, ILLEGAL=15
  - opcode constants
  - alu_control codes
  - imm_src codes
- One natural sub-module: alu_decoder (alu_op, funct3, op5, funct7b5 -> alu_control), combinational.
- The FSM and imm_src decode stay in multicycle_controller.

Test Plan:
- reset=1 for 2 cycles, then release -> state_dbg=0 (FETCH); pc_write=1, ir_write=1, alu_src_b=10 in the first cycle after release.
- op=0000011 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write=1 and result_src=01 only in cycle 5; mem_write stays 0.
- op=0100011 -> mem_write=1 only in cycle 4 with adr_src=1; imm_src=01; reg_write never 1.
- op=0110011, funct3=000, funct7b5=1 -> alu_control=001 in EXECUTER. With op=0010011 and the same fields, alu_control=000 (addi).
- op=1100011, funct3=000: zero=1 -> pc_write=1 in cycle 3; zero=0 -> pc_write=0. funct3=001 gives the inverse.
- op=1111111 -> illegal_instr pulses in DECODE, then FETCH. Separately, assert reset during MEMREAD -> FETCH next cycle and no reg_write pulse.
